// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480 timing constants, pixel format and fetch FSM state type
package vga_pkg;

  // Horizontal timing in pixel clocks
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  // Vertical timing in lines
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Packed RGB 4:4:4 pixel, red in the top nibble
  localparam int VGA_PIX_W = 12;
  localparam int VGA_R_LSB = 8;
  localparam int VGA_G_LSB = 4;
  localparam int VGA_B_LSB = 0;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; read data registered, zero when nothing popped
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush beats both push and pop; a pop on empty reads nothing (no bypass from a same-cycle push)
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy so full and empty are unambiguous
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Registered read port: the popped word appears next cycle, otherwise zero
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_data <= '0;
    end else begin
      pop_data <= do_pop ? mem[rd_ptr] : '0;
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - frame-buffer prefetch into a FIFO and registered RGB/DE output to the DAC
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int ADDR_W     = 19,
  parameter int PIX_W      = VGA_PIX_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hblank,
  input  logic              vblank,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [PIX_W-1:0]  rgb,
  output logic              pix_de,
  output logic              underflow
);

  localparam int FAW         = $clog2(FIFO_DEPTH);
  localparam int FRAME_WORDS = H_VISIBLE * V_VISIBLE;

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic             vblank_q;
  logic             frame_start;
  logic             active;
  logic             pending;
  logic             discard;
  logic             room;
  logic             more;
  logic             push;
  logic             empty;
  logic             full;
  logic [FAW:0]     count;
  logic [ADDR_W:0]  fetch_addr;

  // fetch_addr carries one extra bit so it can reach FRAME_WORDS even when that equals 2^ADDR_W
  assign frame_start = vblank && !vblank_q;
  assign active      = !hblank && !vblank;
  assign pending     = (state == FETCH_REQ);
  assign room        = !full && (({1'b0, count} + (FAW+2)'(pending)) < (FAW+2)'(FIFO_DEPTH));
  assign more        = fetch_addr < (ADDR_W+1)'(FRAME_WORDS);

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .push      (push),
    .push_data (mem_data),
    .pop       (active),
    .pop_data  (rgb),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  // Fetch FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetch FSM: one request in flight; no new request launched on the frame-start cycle itself
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    push       = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (!frame_start && room && more) begin
          state_next = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_next = FETCH_IDLE;
          push       = !discard && !frame_start;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  // Address counter, frame-start edge detect and in-flight discard marker
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q   <= 1'b1;
      fetch_addr <= '0;
      mem_addr   <= '0;
      discard    <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (frame_start) begin
        fetch_addr <= '0;
        discard    <= pending && !mem_ack;
      end else if (pending && mem_ack) begin
        if (!discard) begin
          fetch_addr <= fetch_addr + (ADDR_W+1)'(1);
        end
        discard <= 1'b0;
      end
      if (state == FETCH_IDLE && state_next == FETCH_REQ) begin
        mem_addr <= fetch_addr[ADDR_W-1:0];
      end
    end
  end

  // Data-enable pipeline stage and per-frame sticky underflow
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_de    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pix_de <= active;
      if (frame_start) begin
        underflow <= 1'b0;
      end else if (active && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - scoreboard bench for vga_pixel_fetch on a 16x4 frame
module tb_vga_pixel_fetch;

  localparam int H_VIS  = 16;
  localparam int V_VIS  = 4;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 12;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hblank = 1'b1;
  logic              vblank = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [PIX_W-1:0]  mem_data = '0;
  logic [PIX_W-1:0]  rgb;
  logic              pix_de;
  logic              underflow;

  int total = 0;
  int bad = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic exp_de = 1'b0;
  logic [PIX_W-1:0] exp_q[$];
  int req_log[$];

  always #5 clk = ~clk;

  vga_pixel_fetch #(
    .H_VISIBLE  (H_VIS),
    .V_VISIBLE  (V_VIS),
    .ADDR_W     (ADDR_W),
    .PIX_W      (PIX_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hblank    (hblank),
    .vblank    (vblank),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .rgb       (rgb),
    .pix_de    (pix_de),
    .underflow (underflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // One stimulus cycle; active cycles push the hand-computed pixel expected one clock later
  task automatic cyc(input logic hb, input logic vb, input logic rs, input int pix);
    logic [31:0] p;
    @(posedge clk);
    #1;
    hblank = hb;
    vblank = vb;
    reset  = rs;
    p = pix;
    if (!hb && !vb && !rs) exp_q.push_back(p[PIX_W-1:0]);
  endtask

  task automatic idle(input logic vb, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, vb, 1'b0, 0);
  endtask

  task automatic row(input int first, input int nvalid, input int nempty);
    for (int i = 0; i < nvalid; i++) cyc(1'b0, 1'b0, 1'b0, first + i);
    for (int i = 0; i < nempty; i++) cyc(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Frame-buffer model: acks after ack_delay extra cycles, data = low address bits
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          mem_data = mem_addr[PIX_W-1:0];
          req_log.push_back(int'(mem_addr));
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Expected data enable: the active/reset state the DUT samples at this edge
  initial begin
    forever begin
      @(posedge clk);
      exp_de = !hblank && !vblank && !reset;
    end
  end

  // Monitor: pops one expected pixel per enabled output cycle
  initial begin
    forever begin
      @(negedge clk);
      check("pix_de", {31'd0, pix_de}, {31'd0, exp_de});
      if (pix_de === 1'b1) begin
        check("pix_queue_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("rgb", {20'd0, rgb}, {20'd0, exp_q.pop_front()});
      end else begin
        check("rgb_idle", {20'd0, rgb}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    cyc(1'b1, 1'b1, 1'b1, 0);
    cyc(1'b1, 1'b1, 1'b1, 0);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);

    // Prefetch during vblank: exactly DEPTH requests, then idle
    idle(1'b1, 100);
    @(negedge clk);
    check("prefetch_count", req_log.size(), 32'd16);
    check("prefetch_req_low", {31'd0, mem_req}, 32'd0);
    check("prefetch_underflow", {31'd0, underflow}, 32'd0);

    // Rows 0 and 1 with ideal memory
    row(0, 16, 0);
    idle(1'b0, 40);
    @(negedge clk);
    check("row0_underflow", {31'd0, underflow}, 32'd0);
    row(16, 16, 0);
    idle(1'b0, 40);

    // Row 2 with memory stalled: FIFO drains, then empty pops give zero
    ack_delay = 1000;
    row(32, 16, 8);
    idle(1'b0, 1);
    @(negedge clk);
    check("drain_underflow", {31'd0, underflow}, 32'd1);
    ack_delay = 0;
    idle(1'b0, 40);

    // Row 3 consumes the last words; fetch stops at the frame end
    row(48, 16, 0);
    idle(1'b0, 40);
    @(negedge clk);
    check("frame_req_low", {31'd0, mem_req}, 32'd0);
    check("frame_req_count", req_log.size(), 32'd64);
    check("underflow_sticky", {31'd0, underflow}, 32'd1);
    for (int i = 0; i < 64 && i < req_log.size(); i++) check("frame_addr", req_log[i], i);

    // Next frame start clears underflow and restarts at address 0
    idle(1'b1, 100);
    @(negedge clk);
    check("frame2_underflow", {31'd0, underflow}, 32'd0);
    check("frame2_req_count", req_log.size(), 32'd80);
    for (int i = 0; i < 16 && 64 + i < req_log.size(); i++) check("frame2_addr", req_log[64 + i], i);

    // Frame start while a request is in flight: returned word is dropped
    ack_delay = 1000;
    row(0, 16, 0);
    idle(1'b1, 5);
    ack_delay = 0;
    idle(1'b1, 95);
    @(negedge clk);
    check("flush_req_count", req_log.size(), 32'd97);
    if (req_log.size() > 81) begin
      check("inflight_addr", req_log[80], 32'd16);
      check("restart_addr", req_log[81], 32'd0);
    end

    // First pixels of the new frame come from address 0, then reset mid-row with a request pending
    ack_delay = 1000;
    row(0, 8, 0);
    cyc(1'b0, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_pix_de", {31'd0, pix_de}, 32'd0);
    check("midrst_rgb", {20'd0, rgb}, 32'd0);
    check("midrst_underflow", {31'd0, underflow}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 0);
    idle(1'b0, 1);
    @(negedge clk);
    check("postrst_underflow", {31'd0, underflow}, 32'd1);
    ack_delay = 0;
    idle(1'b0, 40);
    @(negedge clk);
    check("pixels_all_seen", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
